// File: rtl/sub_bytes_seq_pkg.sv
// Shared cipher definitions: byte and state types, state geometry,
// and the forward/inverse AES substitution tables used by the sbox cores.
package sub_bytes_seq_pkg;

    typedef logic [7:0] byte_t;

    localparam int NB          = 4;
    localparam int STATE_BYTES = 16;

    // Row-major: element [r][c] is byte k = r*4 + c; byte 0 is the MSB.
    typedef logic [0:NB-1][0:NB-1][7:0] state_t;

    // Flat view of the same bits, indexed directly by k.
    typedef logic [0:STATE_BYTES-1][7:0] bytes_t;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sub_bytes_seq_sbox.sv
// Combinational AES substitution cores. sbox: lhs -> o (forward);
// inv_sbox (only with SUB_BYTES_SEQ_INV_EN): lhs -> o (inverse).
module sbox
    import sub_bytes_seq_pkg::*;
(
    input  logic [7:0] lhs,
    output logic [7:0] o
);
    assign o = SBOX[lhs];
endmodule

`ifdef SUB_BYTES_SEQ_INV_EN
module inv_sbox
    import sub_bytes_seq_pkg::*;
(
    input  logic [7:0] lhs,
    output logic [7:0] o
);
    assign o = INV_SBOX[lhs];
endmodule
`endif

// File: rtl/sub_bytes_seq.sv
// Sequential SubBytes: LANES shared sboxes swept over the 16 state bytes
// in 16/LANES beats, valid/ready on both sides.
// Ports: clk, rst (async, active-low), in_state/in_valid/in_ready,
// out_state/out_valid/out_ready, busy (high while running).
// SUB_BYTES_SEQ_INV_EN adds input inv (latched on accept) selecting the
// inverse table per block for the decipher path.
module sub_bytes_seq
    import sub_bytes_seq_pkg::*;
#(
    parameter int LANES = 4
)
(
    input  logic   clk,
    input  logic   rst,
`ifdef SUB_BYTES_SEQ_INV_EN
    input  logic   inv,
`endif
    input  state_t in_state,
    input  logic   in_valid,
    output logic   in_ready,
    output state_t out_state,
    output logic   out_valid,
    input  logic   out_ready,
    output logic   busy
);

    localparam int BEATS = STATE_BYTES / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    fsm_t            fsm;
    fsm_t            fsm_next;
    logic [BW-1:0]   beat;
    bytes_t          src;
    bytes_t          dst;
    logic            accept;
    logic [3:0]      lane_k   [LANES];
    byte_t           lane_out [LANES];
`ifdef SUB_BYTES_SEQ_INV_EN
    logic            inv_q;
`endif

    always_comb begin
        fsm_next  = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (beat == LAST) fsm_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // Overlap: the consuming edge may also accept the next block.
                in_ready  = out_ready;
                if (out_ready) fsm_next = in_valid ? RUN : IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        byte_t lane_in;
        byte_t fwd;

        assign lane_k[j] = 4'(int'(beat) * LANES + j);
        assign lane_in   = src[lane_k[j]];

        sbox u_sbox (
            .lhs (lane_in),
            .o   (fwd)
        );

`ifdef SUB_BYTES_SEQ_INV_EN
        byte_t rev;

        inv_sbox u_inv_sbox (
            .lhs (lane_in),
            .o   (rev)
        );

        assign lane_out[j] = inv_q ? rev : fwd;
`else
        assign lane_out[j] = fwd;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm   <= IDLE;
            beat  <= '0;
            src   <= '0;
            dst   <= '0;
`ifdef SUB_BYTES_SEQ_INV_EN
            inv_q <= 1'b0;
`endif
        end else begin
            fsm <= fsm_next;
            if (accept) begin
                src   <= in_state;
                beat  <= '0;
`ifdef SUB_BYTES_SEQ_INV_EN
                inv_q <= inv;
`endif
            end else if (fsm == RUN) begin
                beat <= (beat == LAST) ? '0 : beat + 1'b1;
                // Bytes of later beats keep stale values until written.
                for (int j = 0; j < LANES; j++) begin
                    dst[lane_k[j]] <= lane_out[j];
                end
            end
        end
    end

    assign out_state = dst;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: reset, known vectors, backpressure,
// streaming, mid-run reset, other LANES widths, optional inverse mode.
module tb_sub_bytes_seq;
    import sub_bytes_seq_pkg::*;

    localparam int NX = 4;

    logic   clk = 1'b0;
    logic   rst;
    state_t in_state;
    logic   in_valid;
    logic   in_ready;
    state_t out_state;
    logic   out_valid;
    logic   out_ready;
    logic   busy;
`ifdef SUB_BYTES_SEQ_INV_EN
    logic   inv;
`endif

    state_t x_in_state  [NX];
    logic   x_in_valid  [NX];
    logic   x_in_ready  [NX];
    state_t x_out_state [NX];
    logic   x_out_valid [NX];
    logic   x_out_ready [NX];
    logic   x_busy      [NX];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sub_bytes_seq #(.LANES(4)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SUB_BYTES_SEQ_INV_EN
        .inv       (inv),
`endif
        .in_state  (in_state),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_state (out_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    for (genvar i = 0; i < NX; i++) begin : g_x
        localparam int L = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 8 : 16;
        sub_bytes_seq #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
`ifdef SUB_BYTES_SEQ_INV_EN
            .inv       (1'b0),
`endif
            .in_state  (x_in_state[i]),
            .in_valid  (x_in_valid[i]),
            .in_ready  (x_in_ready[i]),
            .out_state (x_out_state[i]),
            .out_valid (x_out_valid[i]),
            .out_ready (x_out_ready[i]),
            .busy      (x_busy[i])
        );
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input state_t s, input string tag);
        int g;
        g = 0;
        in_state = s;
        in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        check({tag, "_rdy"}, 128'(in_ready), 128'(1'b1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_clr"}, 128'(out_valid), 128'(1'b0));
    endtask

    initial begin
        state_t     kv;
        state_t     ke;
        logic [7:0] sv [8];
        logic [7:0] se [8];
        int         xlat [NX];
        int         lat;
        int         cyc;
        int         last;
        int         got;
        int         idx;
        logic       will_acc;

        kv = {32'h19a09ae9, {3{32'h000153ff}}};
        ke = {32'hd4e0b81e, {3{32'h637ced16}}};
        sv = '{8'h00, 8'h01, 8'h53, 8'hff, 8'h19, 8'ha0, 8'h9a, 8'he9};
        se = '{8'h63, 8'h7c, 8'hed, 8'h16, 8'hd4, 8'he0, 8'hb8, 8'h1e};
        xlat = '{16, 8, 2, 1};

        rst       = 1'b0;
        in_state  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef SUB_BYTES_SEQ_INV_EN
        inv       = 1'b0;
`endif
        for (int i = 0; i < NX; i++) begin
            x_in_state[i]  = '0;
            x_in_valid[i]  = 1'b0;
            x_out_ready[i] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_out_state", out_state, '0);

        offer('0, "zero");
        check("zero_busy", 128'(busy), 128'(1'b1));
        check("zero_in_ready", 128'(in_ready), 128'(1'b0));
        wait_out(lat);
        check("zero_lat", 128'(lat), 128'(4));
        check("zero_state", out_state, {16{8'h63}});
        consume("zero");

        offer(kv, "kv");
        wait_out(lat);
        check("kv_lat", 128'(lat), 128'(4));
        check("kv_state", out_state, ke);

        // Sink stalls while a new block is offered.
        in_state = {16{8'h53}};
        in_valid = 1'b1;
        repeat (10) tick();
        check("bp_state_held", out_state, ke);
        check("bp_in_ready", 128'(in_ready), 128'(1'b0));
        check("bp_out_valid", 128'(out_valid), 128'(1'b1));
        out_ready = 1'b1;
        #1;
        check("bp_rel_in_ready", 128'(in_ready), 128'(1'b1));
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp_ov_clr", 128'(out_valid), 128'(1'b0));
        check("bp_busy", 128'(busy), 128'(1'b1));
        wait_out(lat);
        check("bp_lat", 128'(lat), 128'(4));
        check("bp_state", out_state, {16{8'hed}});
        consume("bp");

        // Streaming: DONE still takes one cycle, so the overlapped period
        // is four RUN beats plus the DONE cycle.
        idx       = 0;
        got       = 0;
        cyc       = 0;
        last      = 0;
        in_state  = {16{sv[0]}};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (got < 8 && cyc < 200) begin
            will_acc = in_valid && in_ready;
            if (out_valid) begin
                check($sformatf("stream_%0d", got), out_state, {16{se[got]}});
                if (got > 0) begin
                    check($sformatf("stream_gap_%0d", got),
                          128'(cyc - last), 128'(5));
                end
                last = cyc;
                got++;
            end
            tick();
            cyc++;
            if (will_acc) begin
                idx++;
                if (idx < 8) in_state = {16{sv[idx]}};
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("stream_count", 128'(got), 128'(8));

        offer(kv, "mid");
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("mid_out_valid", 128'(out_valid), 128'(1'b0));
        check("mid_busy", 128'(busy), 128'(1'b0));
        check("mid_in_ready", 128'(in_ready), 128'(1'b1));
        check("mid_out_state", out_state, '0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("mid_rel_out_valid", 128'(out_valid), 128'(1'b0));
        offer(kv, "fresh");
        wait_out(lat);
        check("fresh_lat", 128'(lat), 128'(4));
        check("fresh_state", out_state, ke);
        consume("fresh");

        for (int i = 0; i < NX; i++) begin
            x_in_state[i] = kv;
            x_in_valid[i] = 1'b1;
            check($sformatf("x%0d_rdy", i), 128'(x_in_ready[i]), 128'(1'b1));
            tick();
            x_in_valid[i] = 1'b0;
            lat = 0;
            while (!x_out_valid[i] && lat < 40) begin
                tick();
                lat++;
            end
            check($sformatf("x%0d_lat", i), 128'(lat), 128'(xlat[i]));
            check($sformatf("x%0d_state", i), x_out_state[i], ke);
            x_out_ready[i] = 1'b1;
            tick();
            x_out_ready[i] = 1'b0;
            check($sformatf("x%0d_ov_clr", i),
                  128'(x_out_valid[i]), 128'(1'b0));
        end

`ifdef SUB_BYTES_SEQ_INV_EN
        inv = 1'b1;
        offer({16{8'h63}}, "inv63");
        inv = 1'b0;
        wait_out(lat);
        check("inv63_lat", 128'(lat), 128'(4));
        check("inv63_state", out_state, '0);
        consume("inv63");

        inv = 1'b1;
        offer({16{8'h16}}, "inv16");
        wait_out(lat);
        check("inv16_state", out_state, {16{8'hff}});
        consume("inv16");

        inv = 1'b0;
        offer(kv, "fwd");
        wait_out(lat);
        check("fwd_state", out_state, ke);
        consume("fwd");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
